// File: rtl/fsm_input_conditioner_pkg.sv
// Shared definitions for the go/jump input conditioner: debounce state
// encodings and the default debounce length.
package fsm_input_conditioner_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } db_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 4;

  localparam int NUM_CH = 2;  // channel 0 = go, channel 1 = jump

endpackage

// File: rtl/fsm_input_conditioner_debounce_channel.sv
// One conditioning channel: 2-flop synchronizer, debounce counter/FSM,
// registered clean level and a one-cycle rising-edge pulse.
module debounce_channel
  import fsm_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit DIRECT = (DEBOUNCE_CYCLES == 1);

  logic             r_s1, r_s2;
  db_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level, r_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_s1   <= raw;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      case (r_state)
        STABLE_LO: begin
          r_level <= 1'b0;
          if (r_s2) begin
            if (DIRECT) begin
              r_state <= STABLE_HI;
              r_level <= 1'b1;
              r_rise  <= 1'b1;
            end else begin
              r_state <= WAIT_HI;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        WAIT_HI: begin
          if (!r_s2) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          r_level <= 1'b1;
          if (!r_s2) begin
            if (DIRECT) begin
              r_state <= STABLE_LO;
              r_level <= 1'b0;
            end else begin
              r_state <= WAIT_LO;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        WAIT_LO: begin
          if (r_s2) begin
            r_state <= STABLE_HI;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= STABLE_LO;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/fsm_input_conditioner.sv
// Go/jump front end: two identical, independent debounce channels feeding
// the FSM go/jump inputs. Priority between the two is left to the FSM.
module fsm_input_conditioner
  import fsm_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic go_raw,
  input  logic jump_raw,
  output logic go,
  output logic jump,
  output logic go_rise,
  output logic jump_rise
);

  logic [NUM_CH-1:0] w_raw, w_level, w_rise;

  assign w_raw = {jump_raw, go_raw};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (w_raw[c]),
      .level (w_level[c]),
      .rise  (w_rise[c])
    );
  end

  assign go        = w_level[0];
  assign jump      = w_level[1];
  assign go_rise   = w_rise[0];
  assign jump_rise = w_rise[1];

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Scoreboard bench for the go/jump conditioner: a window-of-samples reference
// model predicts outputs each edge, a monitor compares them on the falling edge.
module tb_fsm_input_conditioner;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic go_raw = 1'b0, jump_raw = 1'b0;
  logic go, jump, go_rise, jump_rise;

  fsm_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .go_raw    (go_raw),
    .jump_raw  (jump_raw),
    .go        (go),
    .jump      (jump),
    .go_rise   (go_rise),
    .jump_rise (jump_rise)
  );

  always #5 clk = ~clk;

  logic [3:0] sb[$];  // {jump_rise, go_rise, jump, go}
  int vectors = 0;
  int miscompares = 0;

  // Reference: raw reaches the debouncer two samples late; a channel flips its
  // level once the last D delivered samples all disagree with the current level.
  bit [1:0]   m_s1, m_s2, m_out, m_rise;
  bit [D-1:0] m_win[2];

  always @(posedge clk) begin
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0;
      m_win[0] = '0; m_win[1] = '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_win[c]  = {m_win[c][D-2:0], m_s2[c]};
        m_rise[c] = 1'b0;
        if (m_win[c] == {D{~m_out[c]}}) begin
          m_out[c]  = ~m_out[c];
          m_rise[c] = m_out[c];
        end
      end
      m_s2 = m_s1;
      m_s1 = {jump_raw, go_raw};
    end
    sb.push_back({m_rise, m_out});
  end

  // Resets are only ever asserted while clk is high, so a falling reset with
  // clk high is an async assertion; otherwise this is a falling clock edge.
  logic [3:0] act, exp_v;
  always begin
    @(negedge clk or negedge reset);
    if (clk) begin
      #1;
      vectors++;
      act = {jump_rise, go_rise, jump, go};
      if (act !== 4'b0000) begin
        miscompares++;
        $display("FAIL async_reset t=%0t outs=%b expected=0000", $time, act);
      end
      if (sb.size() > 0) sb[0] = 4'b0000;
    end else if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      act   = {jump_rise, go_rise, jump, go};
      vectors++;
      if (act !== exp_v) begin
        miscompares++;
        $display("FAIL outs t=%0t {jr,gr,j,g} actual=%b expected=%b", $time, act, exp_v);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (n) @(posedge clk);
    #2 reset = 1'b1;
    cyc(1);
  endtask

  initial begin
    cyc(3);
    @(posedge clk);
    #2 reset = 1'b1;
    cyc(6);
    // clean go press and release
    go_raw = 1'b1; cyc(10);
    go_raw = 1'b0; cyc(10);
    // short bounce rejected
    go_raw = 1'b1; cyc(3);
    go_raw = 1'b0; cyc(10);
    // stable high with a 2-cycle dropout
    go_raw = 1'b1; cyc(10);
    go_raw = 1'b0; cyc(2);
    go_raw = 1'b1; cyc(8);
    // async reset while go is high
    do_reset(2);
    cyc(8);
    go_raw = 1'b0; cyc(10);
    // simultaneous rise on both channels
    go_raw = 1'b1; jump_raw = 1'b1; cyc(10);
    go_raw = 1'b0; jump_raw = 1'b0; cyc(10);
    // reset during jump WAIT_HI, raw still high afterwards
    jump_raw = 1'b1; cyc(3);
    do_reset(1);
    cyc(10);
    jump_raw = 1'b0; cyc(10);
    // glitch exactly D-1 long, then exactly D long
    go_raw = 1'b1; cyc(D - 1);
    go_raw = 1'b0; cyc(8);
    go_raw = 1'b1; cyc(D);
    go_raw = 1'b0; cyc(10);
    // randomized activity with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) go_raw = ~go_raw;
      if ($urandom_range(0, 4) == 0) jump_raw = ~jump_raw;
      if ($urandom_range(0, 399) == 0) do_reset($urandom_range(1, 2));
      else cyc(1);
    end
    cyc(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
